// File: rtl/mmio_io_bank.sv
// mmio_io_bank: memory-mapped I/O peripheral for the CPU data bus.
// Provides synchronised input channels, writable output registers, sticky
// per-channel change flags with an interrupt mask, and a change-event counter.
// Reads are combinational from registered state (zero-latency loads).
module mmio_io_bank #(
  parameter int          IN_CH       = 2,
  parameter int          IN_W        = 8,
  parameter int          OUT_CH      = 1,
  parameter int          OUT_W       = 16,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    we,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  input  logic [IN_CH*IN_W-1:0]   in_data,
  output logic [OUT_CH*OUT_W-1:0] out_data,
  output logic                    irq
);

  // Word indices (addr[7:2]) of the register map.
  localparam logic [5:0] W_OUT_BASE = 6'h10;
  localparam logic [5:0] W_STATUS   = 6'h20;
  localparam logic [5:0] W_IRQ_EN   = 6'h21;
  localparam logic [5:0] W_CHG_CNT  = 6'h22;

  logic                                 hit;
  logic [5:0]                           word;
  logic                                 wr;
  logic [SYNC_STAGES-1:0][IN_CH*IN_W-1:0] sync_q;
  logic [IN_CH-1:0][IN_W-1:0]           sync_val;
  logic [IN_CH-1:0][IN_W-1:0]           prev_q;
  logic [IN_CH-1:0]                     chg;
  logic                                 any_chg;
  logic [IN_CH-1:0]                     status_q;
  logic [IN_CH-1:0]                     status_w1c;
  logic [IN_CH-1:0]                     irq_en_q;
  logic [31:0]                          chg_cnt_q;
  logic                                 cnt_clr;
  logic [OUT_CH-1:0][OUT_W-1:0]         out_q;
  logic                                 unused_bits;

  // Address decode: the block owns one 256-byte window; byte lanes ignored.
  assign hit     = (addr[31:8] == BASE_ADDR[31:8]);
  assign word    = addr[7:2];
  assign wr      = we & hit;
  assign cnt_clr = wr && (word == W_CHG_CNT);

  // Only the low bits of wdata and the word part of addr carry meaning.
  assign unused_bits = ^{addr[1:0], wdata};

  assign sync_val = sync_q[SYNC_STAGES-1];
  assign out_data = out_q;

  // Per-channel change detect: synchronised value differs from last cycle's.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    chg = '0;
    for (int i = 0; i < IN_CH; i++) begin
      chg[i] = (sync_val[i] != prev_q[i]);
    end
  end

  assign any_chg = |chg;

  // Write-1-to-clear mask for STATUS, only when STATUS itself is addressed.
  always_comb begin
    status_w1c = '0;
    if (wr && (word == W_STATUS)) begin
      status_w1c = wdata[IN_CH-1:0];
    end
  end

  // Input synchroniser chain plus previous-value register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the synchroniser flops are reset too, so pending input
      // samples are discarded and nonzero inputs register as a change later.
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every stage
      // samples the pre-edge value of the stage before it.
      sync_q[0] <= in_data;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= sync_val;
    end
  end

  // Sticky change flags: a new change in the same cycle beats the clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_q <= '0;
    end else begin
      status_q <= (status_q & ~status_w1c) | chg;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_en_q <= '0;
    end else if (wr && (word == W_IRQ_EN)) begin
      irq_en_q <= wdata[IN_CH-1:0];
    end
  end

  // Change-event counter: one count per cycle with any change; a write
  // clears it, and a change in that same cycle leaves it at 1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chg_cnt_q <= '0;
    end else if (cnt_clr) begin
      chg_cnt_q <= {31'b0, any_chg};
    end else if (any_chg) begin
      chg_cnt_q <= chg_cnt_q + 32'd1;
    end
  end

  // Output registers, loaded from the low OUT_W bits of the bus write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q <= '0;
    end else begin
      for (int j = 0; j < OUT_CH; j++) begin
        if (wr && (word == W_OUT_BASE + 6'(j))) begin
          out_q[j] <= wdata[OUT_W-1:0];
        end
      end
    end
  end

  // Registered interrupt from the current flags and mask, so it follows
  // a flag set or clear by one edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq <= 1'b0;
    end else begin
      irq <= |(status_q & irq_en_q);
    end
  end

  // Combinational read mux; misses and unmapped offsets read zero.
  always_comb begin
    rdata = '0;
    if (hit) begin
      for (int i = 0; i < IN_CH; i++) begin
        if (word == 6'(i)) rdata = 32'(sync_val[i]);
      end
      for (int j = 0; j < OUT_CH; j++) begin
        if (word == W_OUT_BASE + 6'(j)) rdata = 32'(out_q[j]);
      end
      case (word)
        W_STATUS:  rdata = 32'(status_q);
        W_IRQ_EN:  rdata = 32'(irq_en_q);
        W_CHG_CNT: rdata = chg_cnt_q;
        default:   ;
      endcase
    end
  end

endmodule

// File: doc/mmio_io_bank.md
# mmio_io_bank

Parametrised memory-mapped I/O peripheral that sits on the CPU data-memory bus beside DMEM and replaces hard-wired operand/result ports. It provides IN_CH synchronised input channels, OUT_CH writable output registers, per-channel sticky change flags with an interrupt mask, and a global change-event counter. Reads are combinational from registered state, so single-cycle cores see zero-latency loads.

## Interface
Parameters:
- IN_CH, 2: number of input channels, 1..16
- IN_W, 8: width of each input channel, 1..32
- OUT_CH, 1: number of output registers, 1..16
- OUT_W, 16: width of each output register, 1..32
- SYNC_STAGES, 2: input synchroniser depth, 2..4
- BASE_ADDR, 32'h0000_1000: byte base of the 256-byte register window, 256-byte aligned

Ports:
- clk  in  1  CPU clock; the block has one clock
- resetn  in  1  asynchronous, active-low reset
- we  in  1  bus write enable, sampled on rising clk
- addr  in  32  bus byte address; addr[1:0] ignored
- wdata  in  32  bus write data
- rdata  out  32  bus read data, combinational from addr and registered state
- in_data  in  IN_CH*IN_W  asynchronous inputs; channel i at [i*IN_W +: IN_W]
- out_data  out  OUT_CH*OUT_W  output registers; channel j at [j*OUT_W +: OUT_W]
- irq  out  1  registered interrupt request

## Operation
- Hit: addr[31:8] == BASE_ADDR[31:8]; offset = addr[7:0]. Miss: rdata = 0, writes ignored.
- Register map (word offsets):
  - 0x00+4*i, i<IN_CH: IN_i, read-only, synchronised value zero-extended
  - 0x40+4*j, j<OUT_CH: OUT_j, RW; write loads wdata[OUT_W-1:0], read zero-extended
  - 0x80: STATUS, bit i = change flag of channel i; write-1-to-clear
  - 0x84: IRQ_EN, RW, bits [IN_CH-1:0]; upper bits read 0
  - 0x88: CHG_CNT, 32-bit wrapping count of cycles in which at least one channel changed; any write clears
  - all other offsets: read 0, writes ignored
- Per channel: SYNC_STAGES-deep flop chain (sync), plus prev register holding the previous sync value. Change detected when sync != prev; sets STATUS[i].
- irq register = |(STATUS & IRQ_EN), next-state evaluated on post-update STATUS/IRQ_EN.
- Simultaneous events:
  - STATUS set and W1C of same bit in one cycle: set wins, bit stays 1.
  - CHG_CNT write and increment in one cycle: result is 1.
  - CHG_CNT at 32'hFFFF_FFFF plus increment wraps to 0.
- Multiple channels changing in one cycle increment CHG_CNT by 1 only.

## Timing
- Reset (asynchronous, resetn=0): sync chains, prev, STATUS, IRQ_EN, CHG_CNT, OUT_j, irq all 0; out_data = 0; rdata follows addr (IN_i reads 0).
- Input latency: in_data change before edge k appears in IN_i after edge k+SYNC_STAGES-1; STATUS bit and CHG_CNT update at edge k+SYNC_STAGES; irq rises at edge k+SYNC_STAGES+1 if enabled.
- Write latency: OUT_j, IRQ_EN, STATUS clear, CHG_CNT clear take effect at the edge where we=1; out_data and rdata show new value immediately after that edge.
- irq falls one edge after the last enabled flag is cleared or masked.
- Nonzero in_data at reset release registers as a change (prev=0), SYNC_STAGES edges later; this is required behaviour.
- Reset asserted mid-operation clears everything immediately, independent of clk; pending synchroniser contents are discarded.

## Test plan
- Reset: resetn=0 with in_data all ones, OUT_0 previously 16'hBEEF -> out_data=0, irq=0, reads of 0x80/0x88 return 0 while reset held.
- Input path (defaults, BASE 0x1000): drive ch0=8'h5A, ch1=8'hA5 after reset settles -> read 0x1000=0x5A, 0x1004=0xA5 after 2 edges; STATUS=0x3, CHG_CNT=1 at edge 3.
- Output/map: write 0x1040 with 0xDEAD_1234 -> out_data=16'h1234, read 0x1040=0x0000_1234; write 0x1044 and 0x2040 -> no state change, reads 0.
- Interrupt: IRQ_EN=0x2, toggle ch0 only -> irq stays 0; toggle ch1 -> irq=1 at k+3; write STATUS 0x2 -> irq=0 one edge later.
- Collision: W1C of bit 0 in same cycle ch0 change is detected -> STATUS[0]=1; CHG_CNT write in same cycle as increment -> CHG_CNT=1.
- Wrap/params: IN_CH=4, IN_W=32, SYNC_STAGES=3, CHG_CNT driven to 32'hFFFF_FFFF by 2^32-1 events or forced -> next change gives 0; 32-bit input latency 3 edges.
